// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - MIPS instruction-fetch stage with PC, imem request and prefetch queue
//
// Ports:
//   clk, rst (async, active-low)
//   fetch_en        - allow new instruction-memory requests (queue drains regardless)
//   redirect_valid  - branch/jump taken; redirect_pc is the target (low two bits ignored)
//   imem_req/imem_addr/imem_rdata - synchronous imem, data returns the cycle after a request
//   out_valid/out_ready/out_inst/out_pc/out_pc_next - queue head handshake towards decode
//   q_count         - occupied queue entries
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt (pops) and perf_flush_cnt
// (redirects that drop a queued entry or an in-flight response).
module if_fetch_queue #(
    parameter int unsigned      PC_W     = 32,
    parameter int unsigned      INST_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter int unsigned      PC_INC   = 4,
    localparam int unsigned     PTR_W    = $clog2(DEPTH),
    localparam int unsigned     CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [PC_W-1:0]   out_pc_next,
    output logic [CNT_W-1:0]  q_count
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);
    localparam logic [CNT_W:0]  DEPTH_W = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [PC_W-1:0]   inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PC_W-1:0]   pc_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_d [DEPTH];

    logic              push;
    logic              pop;
    logic              issue;
    logic [CNT_W:0]    occ_post_pop;

    // A redirect masks the head so no handshake can complete on a stale entry.
    assign out_valid = (count_q != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    // The response to last cycle's request lands now; a redirect drops it.
    assign push      = inflight_q && !redirect_valid;

    // A slot is reserved at issue time, so the in-flight response counts as
    // occupied; a pop this cycle frees its slot immediately.
    assign occ_post_pop = {1'b0, count_q}
                        - {{CNT_W{1'b0}}, pop}
                        + {{CNT_W{1'b0}}, inflight_q};
    assign issue = rst && fetch_en && !redirect_valid && (occ_post_pop < DEPTH_W);

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign out_inst    = inst_mem_q[rd_ptr_q];
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign out_pc_next = out_pc + PC_STEP;
    assign q_count     = count_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inst_mem_d    = inst_mem_q;
        pc_mem_d      = pc_mem_q;

        if (issue) begin
            pc_d = pc_q + PC_STEP;
        end

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~PC_W'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_mem_d[wr_ptr_q] = imem_rdata;
                pc_mem_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                inst_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inst_mem_q    <= inst_mem_d;
            pc_mem_q      <= pc_mem_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_flush_d = perf_flush_q;
        if (pop) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        // Only redirects that actually throw work away count as flushes.
        if (redirect_valid && ((count_q != '0) || inflight_q)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
